// File: rtl/decoder_scan_if.sv
// rtl/decoder_scan_if.sv - control and decode-output bundle for decoder_scan
//
// Purpose: groups the decoder's control inputs and registered outputs.
// Signals:
//   en    - global enable (master -> slave)
//   mode  - 0 = direct decode, 1 = auto-scan (master -> slave)
//   in    - select value for direct mode, SEL_W bits (master -> slave)
//   d     - one-hot or all-zero decode, 2**SEL_W bits (slave -> master)
//   idx   - current select index, SEL_W bits (slave -> master)
//   wrap  - one-cycle pulse on scan wrap (slave -> master)
interface decoder_scan_if #(
  parameter int SEL_W = 3
);
  logic                    en;
  logic                    mode;
  logic [SEL_W-1:0]        in;
  logic [(1<<SEL_W)-1:0]   d;
  logic [SEL_W-1:0]        idx;
  logic                    wrap;

  modport master (output en, output mode, output in, input d, input idx, input wrap);
  modport slave  (input en, input mode, input in, output d, output idx, output wrap);
endinterface

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - one-hot decoder with direct and auto-scan modes
//
// Purpose: registered 2**SEL_W-way one-hot decoder. In direct mode the
// output follows bus.in with one cycle of latency; in scan mode every
// index is held for DIV cycles in turn, with a wrap pulse on 7 -> 0.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - decoder_scan_if slave modport (en, mode, in / d, idx, wrap)
// Optional macro DECODER_SCAN_BLANK_EN: blanks d for the step cycle of
// each scan index change (requires DIV >= 2).
module decoder_scan #(
  parameter int SEL_W = 3,
  parameter int DIV   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_scan_if.slave  bus
);
  localparam int N    = 1 << SEL_W;
  localparam int PC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(DIV - 1);
  localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(N - 1);

  logic [N-1:0]     d_q;
  logic [SEL_W-1:0] idx_q;
  logic [PC_W-1:0]  pc_q;
  logic             mode_q;
  logic             wrap_q;
  logic [SEL_W-1:0] idx_nxt;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [N-1:0] r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

  // Index increment wraps naturally at the SEL_W width.
  assign idx_nxt = idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q    <= '0;
      idx_q  <= '0;
      pc_q   <= '0;
      mode_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (!bus.en) begin
      // Blank the output but freeze all sequencing state, including mode_q,
      // so a mode change made while disabled is seen on re-enable.
      d_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= bus.mode;
      if (!bus.mode) begin
        idx_q  <= bus.in;
        d_q    <= onehot(bus.in);
        pc_q   <= '0;
        wrap_q <= 1'b0;
      end else if (!mode_q) begin
        // Scan entry always restarts at index 0 with a fresh dwell.
        idx_q  <= '0;
        d_q    <= onehot('0);
        pc_q   <= '0;
        wrap_q <= 1'b0;
      end else if (pc_q != PC_LAST) begin
        pc_q   <= pc_q + 1'b1;
        d_q    <= onehot(idx_q);
        wrap_q <= 1'b0;
      end else begin
        pc_q   <= '0;
        idx_q  <= idx_nxt;
        wrap_q <= (idx_q == IDX_MAX);
`ifdef DECODER_SCAN_BLANK_EN
        d_q    <= '0;
`else
        d_q    <= onehot(idx_nxt);
`endif
      end
    end
  end

  assign bus.d    = d_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - self-checking bench for decoder_scan (SEL_W=3, DIV=4)
module tb_decoder_scan;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decoder_scan_if #(.SEL_W(3)) bus ();

  decoder_scan #(.SEL_W(3), .DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] in;
    logic [7:0] exp_d;
    logic [2:0] exp_idx;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[12];

  task automatic drive(input logic r, input logic e, input logic m, input logic [2:0] i);
    rst_n    = r;
    bus.en   = e;
    bus.mode = m;
    bus.in   = i;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] ed, input logic [2:0] ei, input logic ew);
    checks++;
    if (bus.d !== ed || bus.idx !== ei || bus.wrap !== ew) begin
      failures++;
      $display("FAIL %s: got d=%h idx=%0d wrap=%b, want d=%h idx=%0d wrap=%b",
               name, bus.d, bus.idx, bus.wrap, ed, ei, ew);
    end
  endtask

  initial begin
    logic [2:0] eidx;
    logic [7:0] ed;

    vecs[0]  = '{"reset_0",     1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 3'd0, 1'b0};
    vecs[1]  = '{"reset_1",     1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 3'd0, 1'b0};
    vecs[2]  = '{"direct_5",    1'b1, 1'b1, 1'b0, 3'd5, 8'h20, 3'd5, 1'b0};
    vecs[3]  = '{"direct_2",    1'b1, 1'b1, 1'b0, 3'd2, 8'h04, 3'd2, 1'b0};
    vecs[4]  = '{"direct_5b",   1'b1, 1'b1, 1'b0, 3'd5, 8'h20, 3'd5, 1'b0};
    vecs[5]  = '{"en_low",      1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 3'd5, 1'b0};
    vecs[6]  = '{"en_back",     1'b1, 1'b1, 1'b0, 3'd3, 8'h08, 3'd3, 1'b0};
    vecs[7]  = '{"direct_7",    1'b1, 1'b1, 1'b0, 3'd7, 8'h80, 3'd7, 1'b0};
    vecs[8]  = '{"direct_0",    1'b1, 1'b1, 1'b0, 3'd0, 8'h01, 3'd0, 1'b0};
    vecs[9]  = '{"mode_en_low", 1'b1, 1'b0, 1'b1, 3'd4, 8'h00, 3'd0, 1'b0};
    vecs[10] = '{"late_entry",  1'b1, 1'b1, 1'b1, 3'd4, 8'h01, 3'd0, 1'b0};
    vecs[11] = '{"dwell_1",     1'b1, 1'b1, 1'b1, 3'd4, 8'h01, 3'd0, 1'b0};

    drive(1'b0, 1'b1, 1'b1, 3'd0);
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].in);
      step();
      check(vecs[i].name, vecs[i].exp_d, vecs[i].exp_idx, vecs[i].exp_wrap);
    end

    // Leave scan through direct mode, then run a full scan plus the part of
    // the next one that reaches index 6.
    drive(1'b1, 1'b1, 1'b0, 3'd3);
    step();
    check("pre_scan", 8'h08, 3'd3, 1'b0);

    drive(1'b1, 1'b1, 1'b1, 3'd3);
    for (int t = 0; t < 58; t++) begin
      step();
      eidx = 3'((t / 4) % 8);
      ed   = 8'h01 << eidx;
`ifdef DECODER_SCAN_BLANK_EN
      if (t > 0 && (t % 4) == 0) ed = 8'h00;
`endif
      check($sformatf("scan_t%0d", t), ed, eidx, (t == 32));
    end

    // Reset in the middle of the dwell on index 6.
    drive(1'b0, 1'b1, 1'b1, 3'd0);
    step();
    check("mid_reset", 8'h00, 3'd0, 1'b0);

    drive(1'b1, 1'b1, 1'b1, 3'd0);
    for (int t = 0; t < 5; t++) begin
      step();
      eidx = (t < 4) ? 3'd0 : 3'd1;
      ed   = 8'h01 << eidx;
`ifdef DECODER_SCAN_BLANK_EN
      if (t == 4) ed = 8'h00;
`endif
      check($sformatf("reentry_t%0d", t), ed, eidx, 1'b0);
    end

    // Disabling mid-scan blanks d and freezes the dwell counter.
    drive(1'b1, 1'b0, 1'b1, 3'd0);
    step();
    check("scan_en_low", 8'h00, 3'd1, 1'b0);
    step();
    check("scan_en_low2", 8'h00, 3'd1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 3'd0);
    for (int t = 0; t < 4; t++) begin
      step();
      eidx = (t < 3) ? 3'd1 : 3'd2;
      ed   = 8'h01 << eidx;
`ifdef DECODER_SCAN_BLANK_EN
      if (t == 3) ed = 8'h00;
`endif
      check($sformatf("resume_t%0d", t), ed, eidx, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
